// File: rtl/uart_pkg.sv
// Shared UART definitions: data width, line levels and receiver FSM encodings.
package uart_pkg;

  localparam int unsigned DataW = 8;

  // Line levels of an 8N1/8E1 frame, shared with the transmitter.
  localparam logic StartBit  = 1'b0;
  localparam logic StopBit   = 1'b1;
  localparam logic IdleLevel = 1'b1;

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StParity,
    StStop,
    StBreak
  } rx_state_e;

endpackage

// File: rtl/uart_sync2.sv
// Two-flop synchronizer for asynchronous pad inputs, with a configurable reset level.
module uart_sync2 #(
  parameter logic ResetVal = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d_i,
  output logic q_o
);

  logic [1:0] sync_q;

  // Shift the pad value through two flops to settle metastability.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= {2{ResetVal}};
    end else begin
      sync_q <= {sync_q[0], d_i};
    end
  end

  assign q_o = sync_q[1];

endmodule

// File: rtl/uart_rx_8n1.sv
// UART receiver, 8N1 frames, running on the system clock with a bit-timing counter.
// Define UART_RX_PARITY_EN to receive 8E1 frames and report parity mismatches.
// CLKS_PER_BIT (CLK_FREQ / BAUD) must be at least 8.
module uart_rx_8n1
  import uart_pkg::*;
#(
  parameter int unsigned CLK_FREQ = 12_000_000,
  parameter int unsigned BAUD     = 9600
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             rx_i,
  output logic [DataW-1:0] rx_data_o,
  output logic             rx_valid_o,
  input  logic             rx_ready_i,
  output logic             frame_err_o,
  output logic             overrun_o,
  output logic             parity_err_o
);

  localparam int unsigned CLKS_PER_BIT = CLK_FREQ / BAUD;
  localparam int unsigned CntW         = $clog2(CLKS_PER_BIT);
  localparam int unsigned IdxW         = $clog2(DataW);
  localparam logic [CntW-1:0] CntFull  = CntW'(CLKS_PER_BIT - 1);
  localparam logic [CntW-1:0] CntHalf  = CntW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [IdxW-1:0] LastIdx  = IdxW'(DataW - 1);

`ifdef UART_RX_PARITY_EN
  localparam rx_state_e AfterData = StParity;
`else
  localparam rx_state_e AfterData = StStop;
`endif

  logic rx_s;

  uart_sync2 #(
    .ResetVal(IdleLevel)
  ) u_sync (
    .clk  (clk),
    .rst_n(rst_n),
    .d_i  (rx_i),
    .q_o  (rx_s)
  );

  rx_state_e        state_q;
  logic [CntW-1:0]  cnt_q;
  logic [IdxW-1:0]  bit_idx_q;
  logic [DataW-1:0] shift_q;
  logic             done_q;
  logic             frame_err_q;
  logic             expire;

  assign expire = (cnt_q == '0);

`ifdef UART_RX_PARITY_EN
  logic par_bad_q;
`endif

  // Frame FSM: every sample is taken mid-bit when the counter expires.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      bit_idx_q   <= '0;
      shift_q     <= '0;
      done_q      <= 1'b0;
      frame_err_q <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bad_q   <= 1'b0;
`endif
    end else begin
      done_q      <= 1'b0;
      frame_err_q <= 1'b0;
      case (state_q)
        StIdle: begin
          if (rx_s == StartBit) begin
            cnt_q   <= CntHalf;
            state_q <= StStart;
          end
        end
        StStart: begin
          if (!expire) begin
            cnt_q <= cnt_q - 1'b1;
          end else if (rx_s == StartBit) begin
            cnt_q     <= CntFull;
            bit_idx_q <= '0;
            state_q   <= StData;
          end else begin
            state_q <= StIdle;  // too short to be a start bit
          end
        end
        StData: begin
          if (!expire) begin
            cnt_q <= cnt_q - 1'b1;
          end else begin
            shift_q   <= {rx_s, shift_q[DataW-1:1]};
            cnt_q     <= CntFull;
            bit_idx_q <= bit_idx_q + 1'b1;
            if (bit_idx_q == LastIdx) begin
              state_q <= AfterData;
            end
          end
        end
`ifdef UART_RX_PARITY_EN
        StParity: begin
          if (!expire) begin
            cnt_q <= cnt_q - 1'b1;
          end else begin
            // Even parity: data plus parity bit must hold an even number of ones.
            par_bad_q <= ^{shift_q, rx_s};
            cnt_q     <= CntFull;
            state_q   <= StStop;
          end
        end
`endif
        StStop: begin
          if (!expire) begin
            cnt_q <= cnt_q - 1'b1;
          end else if (rx_s == StopBit) begin
            // Leave mid stop bit so a back-to-back start edge is not missed.
            done_q  <= 1'b1;
            state_q <= StIdle;
          end else begin
            frame_err_q <= 1'b1;
            state_q     <= StBreak;
          end
        end
        StBreak: begin
          if (rx_s == IdleLevel) begin
            state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  logic [DataW-1:0] rx_data_q;
  logic             rx_valid_q;
  logic             overrun_q;
  logic             parity_err_q;

  // Output holding register and valid/ready handshake; a completion always wins.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_data_q    <= '0;
      rx_valid_q   <= 1'b0;
      overrun_q    <= 1'b0;
      parity_err_q <= 1'b0;
    end else if (done_q) begin
      rx_data_q    <= shift_q;
      rx_valid_q   <= 1'b1;
      overrun_q    <= rx_valid_q & ~rx_ready_i;
`ifdef UART_RX_PARITY_EN
      parity_err_q <= par_bad_q;
`else
      parity_err_q <= 1'b0;
`endif
    end else begin
      overrun_q    <= 1'b0;
      parity_err_q <= 1'b0;
      if (rx_valid_q && rx_ready_i) begin
        rx_valid_q <= 1'b0;
      end
    end
  end

  assign rx_data_o    = rx_data_q;
  assign rx_valid_o   = rx_valid_q;
  assign overrun_o    = overrun_q;
  assign frame_err_o  = frame_err_q;
  assign parity_err_o = parity_err_q;

endmodule
